// File: rtl/counter_pkg.sv
// Shared types and helpers for the bounded step counter.
package counter_pkg;

  typedef enum logic {CNT_SATURATE = 1'b0, CNT_WRAP = 1'b1} cnt_mode_e;

  // Number of distinct values in the inclusive window [min_v, max_v].
  function automatic int unsigned cnt_range(int unsigned min_v, int unsigned max_v);
    return max_v - min_v + 1;
  endfunction

endpackage

// File: rtl/bounded_step_next.sv
// Next-count computation for one enabled step, with bound handling and event flags.
module bounded_step_next
  import counter_pkg::*;
#(
  parameter int unsigned Width     = 8,
  parameter int unsigned MinValue  = 0,
  parameter int unsigned MaxValue  = 255,
  parameter int unsigned StepWidth = 4
) (
  input  logic [Width-1:0]     i_count,
  input  logic [StepWidth-1:0] i_step,
  input  logic                 i_up,
  input  cnt_mode_e            i_mode,
  output logic [Width-1:0]     o_next,
  output logic                 o_ovf,
  output logic                 o_unf
);

  localparam int unsigned SUMW  = Width + StepWidth + 1;
  localparam int unsigned DIFW  = Width + StepWidth + 2;
  localparam int unsigned RANGE = cnt_range(MinValue, MaxValue);

  localparam logic [SUMW-1:0]        MAX_S   = SUMW'(MaxValue);
  localparam logic [SUMW-1:0]        RANGE_S = SUMW'(RANGE);
  localparam logic signed [DIFW-1:0] MIN_D   = DIFW'(MinValue);
  localparam logic signed [DIFW-1:0] RANGE_D = DIFW'(RANGE);
  localparam logic [Width-1:0]       MAX_W   = Width'(MaxValue);
  localparam logic [Width-1:0]       MIN_W   = Width'(MinValue);

  logic [SUMW-1:0]        w_sum;
  logic signed [DIFW-1:0] w_diff;
  logic [SUMW-1:0]        w_sum_wrap;
  logic signed [DIFW-1:0] w_diff_wrap;

  // Wide enough that neither direction can wrap before the bound compare.
  assign w_sum       = SUMW'(i_count) + SUMW'(i_step);
  assign w_diff      = $signed(DIFW'(i_count)) - $signed(DIFW'(i_step));
  assign w_sum_wrap  = w_sum - RANGE_S;
  assign w_diff_wrap = w_diff + RANGE_D;

  always_comb begin
    o_next = i_count;
    o_ovf  = 1'b0;
    o_unf  = 1'b0;
    if (i_up) begin
      if (w_sum > MAX_S) begin
        o_ovf  = 1'b1;
        o_next = (i_mode == CNT_WRAP) ? Width'(w_sum_wrap) : MAX_W;
      end else begin
        o_next = Width'(w_sum);
      end
    end else begin
      if (w_diff < MIN_D) begin
        o_unf  = 1'b1;
        o_next = (i_mode == CNT_WRAP) ? Width'(w_diff_wrap) : MIN_W;
      end else begin
        o_next = Width'(w_diff);
      end
    end
  end

endmodule

// File: rtl/bounded_step_counter.sv
// Up/down counter confined to [MinValue, MaxValue] with variable step, load,
// saturate/wrap selection and registered overflow/underflow pulses.
module bounded_step_counter
  import counter_pkg::*;
#(
  parameter int unsigned Width     = 8,
  parameter int unsigned MinValue  = 0,
  parameter int unsigned MaxValue  = 255,
  parameter int unsigned StepWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 upDown,
  input  logic [StepWidth-1:0] step,
  input  logic                 wrapMode,
  input  logic                 load,
  input  logic [Width-1:0]     loadValue,
  output logic [Width-1:0]     count,
  output logic                 atMax,
  output logic                 atMin,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned     RANGE = cnt_range(MinValue, MaxValue);
  localparam logic [Width-1:0] MAX_W = Width'(MaxValue);
  localparam logic [Width-1:0] MIN_W = Width'(MinValue);

  if (!(MinValue < MaxValue) || (longint'(MaxValue) > ((longint'(1) << Width) - 1)))
  begin : g_bad_params
    $error("bounded_step_counter: need MinValue < MaxValue <= 2^Width-1");
  end

  logic [Width-1:0]     r_count;
  logic                 r_ovf;
  logic                 r_unf;
  logic [StepWidth-1:0] w_step_eff;
  logic [Width-1:0]     w_load_clamp;
  logic [Width-1:0]     w_next;
  logic                 w_ovf;
  logic                 w_unf;

  // A step larger than the window would lap it more than once; cap it at one lap.
  assign w_step_eff = (64'(step) > 64'(RANGE)) ? StepWidth'(RANGE) : step;

  assign w_load_clamp = (loadValue < MIN_W) ? MIN_W :
                        (loadValue > MAX_W) ? MAX_W : loadValue;

  bounded_step_next #(
    .Width    (Width),
    .MinValue (MinValue),
    .MaxValue (MaxValue),
    .StepWidth(StepWidth)
  ) u_next (
    .i_count(r_count),
    .i_step (w_step_eff),
    .i_up   (upDown),
    .i_mode (cnt_mode_e'(wrapMode)),
    .o_next (w_next),
    .o_ovf  (w_ovf),
    .o_unf  (w_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= MIN_W;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamp;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (en) begin
      r_count <= w_next;
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
    end else begin
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end
  end

  assign count     = r_count;
  assign atMax     = (r_count == MAX_W);
  assign atMin     = (r_count == MIN_W);
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_bounded_step_counter.sv
// Directed-vector bench for bounded_step_counter (window 10..200, range 191).
module tb_bounded_step_counter;

  logic       clk = 1'b0;
  logic       rst, en, upDown, wrapMode, load;
  logic [3:0] step;
  logic [7:0] loadValue;
  logic [7:0] count;
  logic       atMax, atMin, overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  bounded_step_counter #(
    .Width(8), .MinValue(10), .MaxValue(200), .StepWidth(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .upDown(upDown), .step(step),
    .wrapMode(wrapMode), .load(load), .loadValue(loadValue),
    .count(count), .atMax(atMax), .atMin(atMin),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input int c, input int ov, input int un);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".ovf"}, int'(overflow), ov);
    chk({tag, ".unf"}, int'(underflow), un);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; loadValue = 8'(v);
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; loadValue = 8'd100; en = 1'b1;
    upDown = 1'b1; step = 4'd0; wrapMode = 1'b0;
    tick();
    st("reset", 10, 0, 0);
    chk("reset.atMin", int'(atMin), 1);
    chk("reset.atMax", int'(atMax), 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    // saturate up
    do_load(195);
    st("sat_up.load", 195, 0, 0);
    en = 1'b1; upDown = 1'b1; step = 4'd4; wrapMode = 1'b0;
    tick(); st("sat_up.1", 199, 0, 0);
    tick(); st("sat_up.2", 200, 1, 0);
    chk("sat_up.2.atMax", int'(atMax), 1);
    tick(); st("sat_up.3", 200, 1, 0);
    en = 1'b0;
    tick(); st("sat_up.hold", 200, 0, 0);
    chk("sat_up.hold.atMax", int'(atMax), 1);

    // wrap up
    do_load(198);
    en = 1'b1; step = 4'd5; wrapMode = 1'b1;
    tick(); st("wrap_up", 12, 1, 0);
    step = 4'd0;
    tick(); st("wrap_up.step0", 12, 0, 0);

    // in-range down
    en = 1'b0;
    do_load(100);
    en = 1'b1; upDown = 1'b0; step = 4'd7;
    tick(); st("down.inrange", 93, 0, 0);

    // wrap / saturate down
    do_load(11);
    step = 4'd3; wrapMode = 1'b1;
    tick(); st("wrap_down", 199, 0, 1);
    do_load(11);
    st("wrap_down.reload", 11, 0, 0);
    wrapMode = 1'b0;
    tick(); st("sat_down", 10, 0, 1);
    chk("sat_down.atMin", int'(atMin), 1);
    tick(); st("sat_down.again", 10, 0, 1);

    // load clamp and priority over en
    upDown = 1'b1; step = 4'd4;
    do_load(5);   st("clamp.low", 10, 0, 0);
    do_load(250); st("clamp.high", 200, 0, 0);
    do_load(77);  st("clamp.mid", 77, 0, 0);

    // reset mid-operation with an overflow pulse pending
    wrapMode = 1'b1;
    do_load(146);
    tick(); st("mid.150", 150, 0, 0);
    do_load(199);
    step = 4'd15;
    tick(); st("mid.wrap", 23, 1, 0);
    rst = 1'b1;
    tick(); st("mid.rst", 10, 0, 0);
    rst = 1'b0; step = 4'd4;
    tick(); st("mid.resume", 14, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bounded_step_counter.md
Name: bounded_step_counter

Overview:
Parametrised up/down counter bounded to a configurable window [MinValue, MaxValue]. It extends the basic saturating up/down counter with:
- an enable
- a variable step size
- a synchronous load
- run-time selection between saturate and wrap-around modes
- registered overflow/underflow event pulses and boundary flags

It is used as a general-purpose event counter, pointer or credit counter in sequential datapaths.

Parameters:
Width, 8, counter width in bits
MinValue, 0, lower bound of the count window (inclusive)
MaxValue, 255, upper bound of the count window (inclusive); legal when MinValue < MaxValue <= 2^Width-1
StepWidth, 4, width of the step input

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable; one step per cycle while high
upDown  input  1  1 = count up, 0 = count down
step  input  StepWidth  step magnitude for this cycle
wrapMode  input  1  0 = saturate at bounds, 1 = wrap within window
load  input  1  synchronous load strobe
loadValue  input  Width  value to load
count  output  Width  current count, registered
atMax  output  1  count == MaxValue (combinational from count)
atMin  output  1  count == MinValue (combinational from count)
overflow  output  1  registered one-cycle pulse: the previous cycle's enabled up step exceeded MaxValue
underflow  output  1  registered one-cycle pulse: the previous cycle's enabled down step went below MinValue

Behaviour:
- Range = MaxValue - MinValue + 1. An effective step is min(step, Range).
- Priority per cycle: rst > load > en > hold.
- Reset:
  - count = MinValue; overflow = 0; underflow = 0.
  - Hence atMin = 1 and atMax = 0.
  - Takes effect on the next edge, regardless of load/en.
- Load:
  - count = loadValue clamped into [MinValue, MaxValue].
  - overflow = underflow = 0.
  - en is ignored that cycle.
- Enabled up step:
  - sum = count + stepEff, computed at Width+StepWidth+1 bits; no intermediate truncation.
  - If sum <= MaxValue: count = sum.
  - Otherwise, saturate mode: count = MaxValue. Wrap mode: count = sum - Range.
  - In either out-of-range case, overflow = 1 next cycle.
- Enabled down step:
  - diff = count - stepEff, computed signed at Width+StepWidth+2 bits.
  - If diff >= MinValue: count = diff.
  - Otherwise, saturate mode: count = MinValue. Wrap mode: count = diff + Range.
  - In either out-of-range case, underflow = 1 next cycle.
- Step 0 with en: count unchanged; no pulse.
- Holding at a bound with en asserted in the outward direction (saturate mode): count stays, and the pulse re-asserts every such cycle.
- overflow/underflow are never both 1. Both are 0 in any cycle following no event (hold, load, in-range step).
- Latency: count updates one cycle after the inputs are sampled. Pulses align with the count update that caused them.
- No internal state other than count, overflow and underflow.
- An elaboration-time assertion rejects illegal MinValue/MaxValue/Width combinations.

Decomposition:
- Shared package counter_pkg:
  - typedef enum logic {CNT_SATURATE = 1'b0, CNT_WRAP = 1'b1} cnt_mode_e, used for wrapMode.
  - A localparam function computing Range.
- One natural combinational sub-module, bounded_step_next.
  - Inputs: count, effective step, direction, mode.
  - Outputs: next count, overflow event, underflow event.
  - The top level holds the registers, load clamp and priority.

Test Plan (Width=8, MinValue=10, MaxValue=200, StepWidth=4, Range=191):
- Reset: rst=1 with load=1, loadValue=100, en=1 -> count=10, atMin=1, atMax=0, overflow=underflow=0.
- Saturate up: load 195; en=1, upDown=1, step=4, wrapMode=0 for 3 cycles -> count 199, 200 (overflow=1), 200 (overflow=1). Then en=0 -> overflow=0, atMax=1.
- Wrap up: load 198; en=1, upDown=1, step=5, wrapMode=1 -> count=12, overflow=1 for one cycle. Then step=0 -> count=12, overflow=0.
- Wrap/saturate down: load 11; step=3, upDown=0, wrapMode=1 -> count=199, underflow=1. Load 11 again with wrapMode=0 -> count=10, underflow=1.
- Load clamp and priority: load=1, en=1, loadValue=5 -> count=10 with no pulse. loadValue=250 -> count=200. loadValue=77 -> count=77.
- Reset mid-operation: counting up with wrap at count=150 and overflow pulse pending; rst=1 for one cycle -> count=10, overflow=0. Counting resumes from 10 next cycle.
